// File: rtl/online_pkg.sv
// Shared definitions for the MSDF front end:
// digit codes, FSM state type and the digit-count clamp.
package online_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_NEG  = 2'b01;

  localparam logic [1:0] BS_POS  = 2'b01;
  localparam logic [1:0] BS_ZERO = 2'b00;
  localparam logic [1:0] BS_NEG  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // A zero or oversized request means "emit the full operand".
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0 || len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/online_digit_encoder.sv
// Maps one operand bit to a radix-2 signed-digit code.
// Ports: msb (bit value), is_sign (sign position), code (2-bit digit).
module online_digit_encoder
  import online_pkg::*;
#(
  parameter string ENCODING_MODE = "signed-digit"
) (
  input  logic       msb,
  input  logic       is_sign,
  output logic [1:0] code
);

  localparam bit IS_SD = (ENCODING_MODE == "signed-digit");
  localparam bit IS_BS = (ENCODING_MODE == "borrow-save");

  // The sign bit carries weight -1; every other bit is non-negative.
  always_comb begin
    code = 2'b00;
    if (IS_SD) begin
      if (msb) code = is_sign ? SD_NEG : SD_POS;
      else     code = SD_ZERO;
    end else if (IS_BS) begin
      if (msb) code = is_sign ? BS_NEG : BS_POS;
      else     code = BS_ZERO;
    end
  end

endmodule

// File: rtl/online_digit_serializer.sv
// Parallel two's-complement fraction in, MSD-first signed-digit stream out.
// Ports: load channel (valid/ready/data/len), flush, mbus write channel, last, busy.
module online_digit_serializer
  import online_pkg::*;
#(
  parameter string ENCODING_MODE = "signed-digit",
  parameter int    ACCURATE_MAX  = 64,
  parameter int    CNT_WIDTH     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [ACCURATE_MAX-1:0] i_load_data,
  input  logic [CNT_WIDTH-1:0]    i_load_len,
  input  logic                    i_flush,
  output logic                    o_mbus_wen,
  output logic [1:0]              o_mbus_wdata,
  output logic                    o_mbus_wvalid,
  input  logic                    i_mbus_wready,
  output logic                    o_last,
  output logic                    o_busy
);

  state_t                  state;
  logic [ACCURATE_MAX-1:0] sreg;
  logic [CNT_WIDTH-1:0]    count;
  logic                    first;
  logic [CNT_WIDTH-1:0]    eff_len;
  logic [1:0]              code;
  logic                    emit;

  assign eff_len = CNT_WIDTH'(clamp_len(int'(i_load_len), ACCURATE_MAX));
  assign emit    = (state == EMIT);

  online_digit_encoder #(
    .ENCODING_MODE(ENCODING_MODE)
  ) u_enc (
    .msb    (sreg[ACCURATE_MAX-1]),
    .is_sign(first),
    .code   (code)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state <= IDLE;
      sreg  <= '0;
      count <= '0;
      first <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_load_valid) begin
            sreg  <= i_load_data;
            count <= eff_len;
            first <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (i_mbus_wready) begin
            sreg  <= {sreg[ACCURATE_MAX-2:0], 1'b0};
            count <= count - CNT_WIDTH'(1);
            first <= 1'b0;
            if (count == CNT_WIDTH'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_load_ready  = !emit;
  assign o_busy        = emit;
  assign o_mbus_wen    = emit;
  assign o_mbus_wvalid = emit;
  assign o_mbus_wdata  = emit ? code : 2'b00;
  assign o_last        = emit && (count == CNT_WIDTH'(1));

endmodule
